seq_alu: RTL and testbench
==========================

SEQ_ALU -- requirements
Module: seq_alu

Interface
REQ-001 The block SHALL have parameter WIDTH, default 4, setting the operand/result width; legal range 2..32.
REQ-002 The block SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-003 The block SHALL have port rst, input, 1 bit: synchronous, active-high reset.
REQ-004 The block SHALL have port in_valid, input, 1 bit: operands and opcode present.
REQ-005 The block SHALL have port in_ready, output, 1 bit: block can accept an operation.
REQ-006 The block SHALL have port A, input, WIDTH bits: operand A, unsigned/two's complement.
REQ-007 The block SHALL have port B, input, WIDTH bits: operand B.
REQ-008 The block SHALL have port alu_opcode, input, 3 bits: operation select.
REQ-009 The block SHALL have port out_valid, output, 1 bit: result registers hold a valid result.
REQ-010 The block SHALL have port out_ready, input, 1 bit: consumer takes the result.
REQ-011 The block SHALL have port D, output, WIDTH bits: registered result.
REQ-012 The block SHALL have port zero_flag, output, 1 bit: D == 0.
REQ-013 The block SHALL have port carry_flag, output, 1 bit: carry/borrow/overflow-out per opcode.

Function
REQ-014 Opcodes SHALL be: 000 ADD A+B; 001 SUB A-B; 010 AND; 011 OR; 100 XOR; 101 NOT A; 110 SHL A by 1; 111 MUL A*B (unsigned).
REQ-015 A transfer SHALL occur on an edge where in_valid && in_ready; A, B and opcode are captured only then.
REQ-016 The FSM SHALL have states IDLE, MUL, DONE; in_ready = 1 only in IDLE; out_valid = 1 only in DONE.
REQ-017 IDLE -> DONE on a transfer with opcode 000..110; D/flags are loaded on that same edge (latency 1: out_valid high the next cycle).
REQ-018 IDLE -> MUL on a transfer with opcode 111; product accumulator cleared, iteration counter loaded with WIDTH.
REQ-019 MUL SHALL perform one shift-add step per cycle (LSB-first on B); after exactly WIDTH cycles in MUL the state becomes DONE (out_valid high WIDTH+1 cycles after the transfer).
REQ-020 DONE -> IDLE on an edge with out_ready = 1; D and flags SHALL hold stable while out_valid && !out_ready.
REQ-021 No new operation SHALL be accepted in the same cycle that DONE is exited (in_ready is low in DONE); back-to-back throughput is one op per 2 cycles minimum.
REQ-022 ADD: D = (A+B) mod 2^WIDTH, carry_flag = bit WIDTH of the sum.
REQ-023 SUB: D = (A-B) mod 2^WIDTH, carry_flag = 1 iff A < B (borrow, unsigned).
REQ-024 AND/OR/XOR/NOT: bitwise, carry_flag = 0.
REQ-025 SHL: D = {A[WIDTH-2:0],0}, carry_flag = A[WIDTH-1].
REQ-026 MUL: D = low WIDTH bits of the 2*WIDTH product, carry_flag = 1 iff any high WIDTH bits are nonzero.
REQ-027 zero_flag SHALL be registered with D and equal (D == 0) whenever out_valid is high.
REQ-028 in_valid while not in IDLE SHALL be ignored; inputs changing mid-MUL SHALL not affect the result.

Reset
REQ-029 While rst is high at a clock edge: state = IDLE, D = 0, zero_flag = 0, carry_flag = 0, out_valid = 0, in_ready = 1 the following cycle; accumulator and counter cleared.
REQ-030 rst SHALL take priority over any transfer or FSM step in the same edge, including mid-MUL and in DONE; the aborted result is discarded and never presented.

Verification
REQ-031 WIDTH=4, ADD A=1101 B=0011, out_ready=1 -> next cycle out_valid=1, D=0000, zero_flag=1, carry_flag=1; IDLE the cycle after.
REQ-032 WIDTH=4, SUB A=0001 B=0010 -> D=1111, carry_flag=1, zero_flag=0, latency 1.
REQ-033 WIDTH=4, MUL A=0101 B=0011 -> out_valid exactly 5 cycles after transfer, D=1111, carry_flag=0; MUL 1111*1111 -> D=0001, carry_flag=1.
REQ-034 Backpressure: SHL A=1000 with out_ready=0 for 3 cycles -> D=0000, carry_flag=1, zero_flag=1 held stable, in_ready=0 throughout; release -> IDLE next cycle.
REQ-035 rst asserted on 2nd MUL cycle -> out_valid never asserts for that op, all outputs 0, in_ready=1 after reset; next ADD 0010+0010 -> D=0100.
REQ-036 Sweep all opcodes at WIDTH=8 with randomised operands vs. a reference model, including in_valid held high during MUL (must be ignored).

Source files
------------

// File: rtl/seq_alu.sv
// Sequential ALU with a valid/ready handshake: single-cycle logic/arith ops and
// a WIDTH-cycle shift-add multiplier, result held in registers until consumed.
module seq_alu #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic [2:0]       alu_opcode,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] D,
    output logic             zero_flag,
    output logic             carry_flag
);
    localparam int CW = $clog2(WIDTH + 1);

    localparam logic [2:0] OP_ADD = 3'b000;
    localparam logic [2:0] OP_SUB = 3'b001;
    localparam logic [2:0] OP_AND = 3'b010;
    localparam logic [2:0] OP_OR  = 3'b011;
    localparam logic [2:0] OP_XOR = 3'b100;
    localparam logic [2:0] OP_NOT = 3'b101;
    localparam logic [2:0] OP_SHL = 3'b110;
    localparam logic [2:0] OP_MUL = 3'b111;

    typedef enum logic [1:0] {S_IDLE, S_MUL, S_DONE} state_t;

    state_t               state_q, state_d;
    logic [WIDTH-1:0]     d_q, d_d;
    logic                 zf_q, zf_d;
    logic                 cf_q, cf_d;
    logic [2*WIDTH-1:0]   acc_q, acc_d;
    logic [2*WIDTH-1:0]   mcand_q, mcand_d;
    logic [WIDTH-1:0]     mplier_q, mplier_d;
    logic [CW-1:0]        cnt_q, cnt_d;

    logic                 xfer;
    logic                 mul_last;
    logic [WIDTH:0]       sum;
    logic [WIDTH:0]       diff;
    logic [WIDTH-1:0]     alu_res;
    logic                 alu_carry;
    logic [2*WIDTH-1:0]   acc_step;

    assign xfer     = in_valid && (state_q == S_IDLE);
    assign mul_last = (state_q == S_MUL) && (cnt_q == CW'(1));

    // Single-cycle ops; the extra MSB of sum/diff is carry-out / borrow.
    always_comb begin
        sum       = {1'b0, A} + {1'b0, B};
        diff      = {1'b0, A} - {1'b0, B};
        alu_res   = '0;
        alu_carry = 1'b0;
        case (alu_opcode)
            OP_ADD: begin
                alu_res   = sum[WIDTH-1:0];
                alu_carry = sum[WIDTH];
            end
            OP_SUB: begin
                alu_res   = diff[WIDTH-1:0];
                alu_carry = diff[WIDTH];
            end
            OP_AND: alu_res = A & B;
            OP_OR:  alu_res = A | B;
            OP_XOR: alu_res = A ^ B;
            OP_NOT: alu_res = ~A;
            OP_SHL: begin
                alu_res   = {A[WIDTH-2:0], 1'b0};
                alu_carry = A[WIDTH-1];
            end
            default: begin
                alu_res   = '0;
                alu_carry = 1'b0;
            end
        endcase
    end

    // One LSB-first partial product per MUL cycle.
    assign acc_step = mplier_q[0] ? (acc_q + mcand_q) : acc_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                if (xfer) begin
                    state_d = (alu_opcode == OP_MUL) ? S_MUL : S_DONE;
                end
            end
            S_MUL: begin
                if (cnt_q == CW'(1)) begin
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                if (out_ready) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        in_ready   = (state_q == S_IDLE);
        out_valid  = (state_q == S_DONE);
        D          = d_q;
        zero_flag  = zf_q;
        carry_flag = cf_q;
    end

    always_comb begin
        d_d      = d_q;
        zf_d     = zf_q;
        cf_d     = cf_q;
        acc_d    = acc_q;
        mcand_d  = mcand_q;
        mplier_d = mplier_q;
        cnt_d    = cnt_q;
        if (xfer) begin
            if (alu_opcode == OP_MUL) begin
                acc_d    = '0;
                mcand_d  = {{WIDTH{1'b0}}, A};
                mplier_d = B;
                cnt_d    = CW'(WIDTH);
            end else begin
                d_d  = alu_res;
                zf_d = (alu_res == '0);
                cf_d = alu_carry;
            end
        end else if (state_q == S_MUL) begin
            acc_d    = acc_step;
            mcand_d  = mcand_q << 1;
            mplier_d = mplier_q >> 1;
            cnt_d    = cnt_q - CW'(1);
            if (mul_last) begin
                d_d  = acc_step[WIDTH-1:0];
                zf_d = (acc_step[WIDTH-1:0] == '0);
                cf_d = |acc_step[2*WIDTH-1:WIDTH];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            d_q      <= '0;
            zf_q     <= 1'b0;
            cf_q     <= 1'b0;
            acc_q    <= '0;
            mcand_q  <= '0;
            mplier_q <= '0;
            cnt_q    <= '0;
        end else begin
            d_q      <= d_d;
            zf_q     <= zf_d;
            cf_q     <= cf_d;
            acc_q    <= acc_d;
            mcand_q  <= mcand_d;
            mplier_q <= mplier_d;
            cnt_q    <= cnt_d;
        end
    end

endmodule

// File: tb/tb_seq_alu.sv
// Scoreboard bench for seq_alu: a WIDTH=4 instance for directed cases and a
// WIDTH=8 instance for a randomised opcode sweep against a behavioural model.
module tb_seq_alu;
    typedef struct {
        logic [31:0] d;
        logic        z;
        logic        c;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst;

    logic       v4, rdy4, ov4, or4, z4, c4;
    logic [3:0] a4, b4, d4;
    logic [2:0] op4;
    logic       v8, rdy8, ov8, or8, z8, c8;
    logic [7:0] a8, b8, d8;
    logic [2:0] op8;

    exp_t q4[$];
    exp_t q8[$];
    int   checks = 0;
    int   failures = 0;

    always #5 clk = ~clk;

    seq_alu #(.WIDTH(4)) u_alu4 (
        .clk(clk), .rst(rst), .in_valid(v4), .in_ready(rdy4), .A(a4), .B(b4),
        .alu_opcode(op4), .out_valid(ov4), .out_ready(or4), .D(d4),
        .zero_flag(z4), .carry_flag(c4)
    );

    seq_alu #(.WIDTH(8)) u_alu8 (
        .clk(clk), .rst(rst), .in_valid(v8), .in_ready(rdy8), .A(a8), .B(b8),
        .alu_opcode(op8), .out_valid(ov8), .out_ready(or8), .D(d8),
        .zero_flag(z8), .carry_flag(c8)
    );

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h", tag, act, exp);
        end
    endtask

    function automatic logic [32:0] model(input int w, input logic [2:0] op,
                                          input logic [31:0] a, input logic [31:0] b);
        logic [63:0] mask, s, p;
        logic [31:0] d;
        logic        c;
        mask = (64'd1 << w) - 64'd1;
        c = 1'b0;
        d = '0;
        case (op)
            3'd0: begin s = {32'd0, a} + {32'd0, b}; d = 32'(s & mask); c = s[w]; end
            3'd1: begin d = 32'((a - b) & mask[31:0]); c = (a < b); end
            3'd2: d = a & b;
            3'd3: d = a | b;
            3'd4: d = a ^ b;
            3'd5: d = 32'(~a & mask[31:0]);
            3'd6: begin d = 32'((a << 1) & mask[31:0]); c = a[w-1]; end
            default: begin
                p = {32'd0, a} * {32'd0, b};
                d = 32'(p & mask);
                c = ((p >> w) != 64'd0);
            end
        endcase
        return {c, d};
    endfunction

    exp_t e4, e8;
    always @(negedge clk) begin
        if (ov4 && or4) begin
            if (q4.size() == 0) chk("w4_unexpected_out", 32'(ov4), 32'd0);
            else begin
                e4 = q4.pop_front();
                chk("w4_D", 32'(d4), e4.d);
                chk("w4_zero", 32'(z4), 32'(e4.z));
                chk("w4_carry", 32'(c4), 32'(e4.c));
            end
        end
        if (ov8 && or8) begin
            if (q8.size() == 0) chk("w8_unexpected_out", 32'(ov8), 32'd0);
            else begin
                e8 = q8.pop_front();
                chk("w8_D", 32'(d8), e8.d);
                chk("w8_zero", 32'(z8), 32'(e8.z));
                chk("w8_carry", 32'(c8), 32'(e8.c));
            end
        end
    end

    // Drives one op, checks latency, optional backpressure hold and return to IDLE.
    task automatic run_op(input bit w8, input logic [2:0] op, input logic [31:0] ai,
                          input logic [31:0] bi, input int stall, input bit vhold);
        exp_t        e;
        logic [32:0] r;
        logic [31:0] a, b, mask;
        int          w, n;
        string       t;
        w = w8 ? 8 : 4;
        t = w8 ? "w8" : "w4";
        mask = (32'd1 << w) - 32'd1;
        a = ai & mask;
        b = bi & mask;
        r = model(w, op, a, b);
        e.d = r[31:0];
        e.c = r[32];
        e.z = (r[31:0] == 32'd0);
        n = 0;
        while (!(w8 ? rdy8 : rdy4) && n < 50) begin @(posedge clk); #1; n++; end
        if (n >= 50) chk({t, "_idle_timeout"}, 32'(w8 ? rdy8 : rdy4), 32'd1);
        if (w8) begin
            a8 = a[7:0]; b8 = b[7:0]; op8 = op; v8 = 1'b1; or8 = (stall == 0);
            q8.push_back(e);
        end else begin
            a4 = a[3:0]; b4 = b[3:0]; op4 = op; v4 = 1'b1; or4 = (stall == 0);
            q4.push_back(e);
        end
        @(posedge clk); #1;
        if (!vhold) begin
            if (w8) v8 = 1'b0; else v4 = 1'b0;
        end
        n = 1;
        while (!(w8 ? ov8 : ov4) && n < 40) begin
            chk({t, "_busy_ready"}, 32'(w8 ? rdy8 : rdy4), 32'd0);
            if (vhold) begin
                if (w8) begin a8 = 8'($urandom); b8 = 8'($urandom); op8 = 3'($urandom_range(0, 7)); end
                else begin a4 = 4'($urandom); b4 = 4'($urandom); op4 = 3'($urandom_range(0, 7)); end
            end
            @(posedge clk); #1; n++;
        end
        chk({t, "_latency"}, n, (op == 3'b111) ? w + 1 : 1);
        if (w8) v8 = 1'b0; else v4 = 1'b0;
        for (int s = 0; s < stall; s++) begin
            chk({t, "_hold_valid"}, 32'(w8 ? ov8 : ov4), 32'd1);
            chk({t, "_hold_D"}, 32'(w8 ? d8 : d4), e.d);
            chk({t, "_hold_zero"}, 32'(w8 ? z8 : z4), 32'(e.z));
            chk({t, "_hold_carry"}, 32'(w8 ? c8 : c4), 32'(e.c));
            chk({t, "_hold_ready"}, 32'(w8 ? rdy8 : rdy4), 32'd0);
            @(posedge clk); #1;
        end
        if (w8) or8 = 1'b1; else or4 = 1'b1;
        @(posedge clk); #1;
        chk({t, "_exit_valid"}, 32'(w8 ? ov8 : ov4), 32'd0);
        chk({t, "_exit_ready"}, 32'(w8 ? rdy8 : rdy4), 32'd1);
    endtask

    initial begin
        rst = 1'b1;
        v4 = 0; a4 = 0; b4 = 0; op4 = 0; or4 = 0;
        v8 = 0; a8 = 0; b8 = 0; op8 = 0; or8 = 0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_w4_valid", 32'(ov4), 32'd0);
        chk("rst_w4_D", 32'(d4), 32'd0);
        chk("rst_w4_flags", {30'd0, z4, c4}, 32'd0);
        chk("rst_w4_ready", 32'(rdy4), 32'd1);
        chk("rst_w8_valid", 32'(ov8), 32'd0);
        chk("rst_w8_D", 32'(d8), 32'd0);
        chk("rst_w8_ready", 32'(rdy8), 32'd1);
        rst = 1'b0;

        run_op(1'b0, 3'b000, 32'hD, 32'h3, 0, 1'b0);
        run_op(1'b0, 3'b001, 32'h1, 32'h2, 0, 1'b0);
        run_op(1'b0, 3'b111, 32'h5, 32'h3, 0, 1'b0);
        run_op(1'b0, 3'b111, 32'hF, 32'hF, 0, 1'b1);
        run_op(1'b0, 3'b110, 32'h8, 32'h0, 3, 1'b0);
        run_op(1'b0, 3'b101, 32'h6, 32'h0, 1, 1'b0);

        // Reset during the second MUL cycle: the product must never appear.
        @(posedge clk); #1;
        a4 = 4'h7; b4 = 4'h6; op4 = 3'b111; v4 = 1'b1; or4 = 1'b1;
        @(posedge clk); #1;
        v4 = 1'b0;
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        chk("abort_valid", 32'(ov4), 32'd0);
        chk("abort_D", 32'(d4), 32'd0);
        chk("abort_flags", {30'd0, z4, c4}, 32'd0);
        chk("abort_ready", 32'(rdy4), 32'd1);
        for (int i = 0; i < 6; i++) begin
            @(posedge clk); #1;
            chk("abort_no_valid", 32'(ov4), 32'd0);
        end
        run_op(1'b0, 3'b000, 32'h2, 32'h2, 0, 1'b0);

        run_op(1'b1, 3'b000, 32'hFF, 32'h01, 0, 1'b0);
        run_op(1'b1, 3'b001, 32'h00, 32'h01, 1, 1'b0);
        run_op(1'b1, 3'b111, 32'hFF, 32'hFF, 2, 1'b1);
        run_op(1'b1, 3'b111, 32'h00, 32'hA5, 0, 1'b0);
        run_op(1'b1, 3'b110, 32'h80, 32'h00, 0, 1'b0);
        for (int i = 0; i < 40; i++) begin
            run_op(1'b1, 3'(i % 8), $urandom, $urandom, $urandom_range(0, 2),
                   (i % 8 == 7) && (i % 16 == 7));
        end

        repeat (3) @(posedge clk);
        #1;
        chk("w4_queue_empty", q4.size(), 32'd0);
        chk("w8_queue_empty", q8.size(), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
